// File: rtl/pe_sequencer_pkg.sv
// rtl/pe_sequencer_pkg.sv - shared FSM state type and pipeline constants for the PE sequencer
`ifndef ADDR_FIFO
`define ADDR_FIFO 10
`endif

package pe_sequencer_pkg;

    localparam int K        = 3;
    localparam int ADD_LAT  = 5;
    localparam int NL_LAT   = 1;
    localparam int POOL_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_FILT = 3'd1,
        ST_PRIME     = 3'd2,
        ST_RUN       = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

endpackage

// File: rtl/pe_strobe_pipe.sv
// rtl/pe_strobe_pipe.sv - single-bit shift-register delay line with synchronous flush
module pe_strobe_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush_i,
    input  logic din_i,
    output logic dout_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    generate
        if (DEPTH == 1) begin : g_one
            assign sr_d = din_i;
        end else begin : g_multi
            assign sr_d = {sr_q[DEPTH-2:0], din_i};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/pe_sequencer.sv
// rtl/pe_sequencer.sv - convolver job sequencer: filter load, line priming, MAC run and output drain
module pe_sequencer
    import pe_sequencer_pkg::*;
#(
    parameter int N_PE     = 32,
    parameter int W_ADDR   = `ADDR_FIFO,
    parameter int K        = pe_sequencer_pkg::K,
    parameter int ADD_LAT  = pe_sequencer_pkg::ADD_LAT,
    parameter int NL_LAT   = pe_sequencer_pkg::NL_LAT,
    parameter int POOL_LAT = pe_sequencer_pkg::POOL_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [W_ADDR-1:0] cfg_row_length,
    input  logic [W_ADDR-1:0] cfg_num_rows,
    input  logic [N_PE-1:0]   cfg_ch_mask,
    input  logic              cfg_final_bank,
    input  logic              cfg_pool_en,
    input  logic [2:0]        cfg_nl_type,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N_PE-1:0]   shifting_filter,
    output logic [N_PE-1:0]   shifting_line,
    output logic [N_PE-1:0]   mac_enable,
    output logic              line_buffer_reset,
    output logic              adder_enable,
    output logic              nl_enable,
    output logic              pool_enable,
    output logic              final_filter_bank,
    output logic [2:0]        nl_type,
    output logic [W_ADDR-1:0] row_length,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              out_valid
);

    localparam int CW        = W_ADDR + 2;
    localparam int DRAIN_LEN = 1 + ADD_LAT + NL_LAT + POOL_LAT;

    localparam logic [CW-1:0]     FILT_LAST  = CW'(K * K - 1);
    localparam logic [CW-1:0]     DRAIN_LAST = CW'(DRAIN_LEN);
    localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]     C_KM1      = CW'(K - 1);
    localparam logic [W_ADDR-1:0] A_ONE      = W_ADDR'(1);
    localparam logic [W_ADDR-1:0] A_K        = W_ADDR'(K);
    localparam logic [W_ADDR-1:0] A_KM1      = W_ADDR'(K - 1);

    state_e state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W_ADDR-1:0] col_q, col_d;
    logic [W_ADDR-1:0] row_q, row_d;

    logic [W_ADDR-1:0] row_len_q;
    logic [W_ADDR-1:0] num_rows_q;
    logic [N_PE-1:0]   mask_q;
    logic              final_q;
    logic              pool_en_q;
    logic [2:0]        nl_type_q;

    logic [N_PE-1:0]   mac_q, mac_d;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              cfg_err_q;
    logic              lbr_q;

    logic              xfer;
    logic              abort_job;
    logic              start_ok;
    logic              cfg_bad;
    logic [CW-1:0]     prime_last;
    logic              adder_en;
    logic              nl_en;
    logic              pool_en;
    logic              out_en;

    assign xfer       = in_valid & in_ready_q;
    assign abort_job  = abort & (state_q != ST_IDLE);
    assign start_ok   = (state_q == ST_IDLE) & start & ~abort;
    assign cfg_bad    = (cfg_row_length < A_K) | (cfg_num_rows < A_K);
    assign prime_last = C_KM1 * {2'b00, row_len_q} - CNT_ONE;

    // Column counter indexes the current pixel; a full K-wide window exists from col K-1 on.
    assign mac_d = (state_q == ST_RUN && xfer && col_q >= A_KM1 && !abort) ? mask_q : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = cfg_bad ? ST_DONE : ST_LOAD_FILT;
                    cnt_d   = '0;
                end
            end
            ST_LOAD_FILT: begin
                if (xfer) begin
                    if (cnt_q == FILT_LAST) begin
                        state_d = ST_PRIME;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_PRIME: begin
                if (xfer) begin
                    if (cnt_q == prime_last) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        col_d   = '0;
                        row_d   = A_KM1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    if (col_q == row_len_q - A_ONE) begin
                        col_d = '0;
                        if (row_q == num_rows_q - A_ONE) begin
                            state_d = ST_DRAIN;
                            cnt_d   = '0;
                        end else begin
                            row_d = row_q + A_ONE;
                        end
                    end else begin
                        col_d = col_q + A_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_job) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            col_d   = '0;
            row_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_len_q  <= '0;
            num_rows_q <= '0;
            mask_q     <= '0;
            final_q    <= 1'b0;
            pool_en_q  <= 1'b0;
            nl_type_q  <= '0;
            mac_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            lbr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            mac_q      <= mac_d;
            in_ready_q <= (state_d == ST_LOAD_FILT) | (state_d == ST_PRIME) | (state_d == ST_RUN);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
            lbr_q      <= (start_ok & ~cfg_bad) | abort_job;
            if (start_ok) begin
                row_len_q  <= cfg_row_length;
                num_rows_q <= cfg_num_rows;
                mask_q     <= cfg_ch_mask;
                final_q    <= cfg_final_bank;
                pool_en_q  <= cfg_pool_en;
                nl_type_q  <= cfg_nl_type;
                cfg_err_q  <= cfg_bad;
            end
        end
    end

    // Shift strobes qualify the registered ready with the live valid so the shift lands on the word's cycle.
    assign shifting_filter = (state_q == ST_LOAD_FILT && xfer) ? mask_q : '0;
    assign shifting_line   = ((state_q == ST_PRIME || state_q == ST_RUN) && xfer) ? mask_q : '0;

    pe_strobe_pipe #(.DEPTH(1)) u_adder_pipe (
        .clk    (clk),
        .rst    (rst),
        .flush_i(abort_job),
        .din_i  (|mac_q),
        .dout_o (adder_en)
    );

    pe_strobe_pipe #(.DEPTH(ADD_LAT)) u_nl_pipe (
        .clk    (clk),
        .rst    (rst),
        .flush_i(abort_job),
        .din_i  (adder_en),
        .dout_o (nl_en)
    );

    pe_strobe_pipe #(.DEPTH(NL_LAT)) u_pool_pipe (
        .clk    (clk),
        .rst    (rst),
        .flush_i(abort_job),
        .din_i  (nl_en & pool_en_q),
        .dout_o (pool_en)
    );

    pe_strobe_pipe #(.DEPTH(POOL_LAT)) u_out_pipe (
        .clk    (clk),
        .rst    (rst),
        .flush_i(abort_job),
        .din_i  (pool_en_q ? pool_en : nl_en),
        .dout_o (out_en)
    );

    assign mac_enable        = mac_q;
    assign in_ready          = in_ready_q;
    assign line_buffer_reset = lbr_q;
    assign adder_enable      = adder_en;
    assign nl_enable         = nl_en;
    assign pool_enable       = pool_en;
    assign out_valid         = out_en;
    assign final_filter_bank = final_q;
    assign nl_type           = nl_type_q;
    assign row_length        = row_len_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign cfg_err           = cfg_err_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// tb/tb_pe_sequencer.sv - self-checking bench for pe_sequencer: job table, scoreboard and corner sequences
`ifndef ADDR_FIFO
`define ADDR_FIFO 10
`endif

module tb_pe_sequencer;

    localparam int N_PE = 32;
    localparam int W    = `ADDR_FIFO;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic [W-1:0]    cfg_row_length;
    logic [W-1:0]    cfg_num_rows;
    logic [N_PE-1:0] cfg_ch_mask;
    logic            cfg_final_bank;
    logic            cfg_pool_en;
    logic [2:0]      cfg_nl_type;
    logic            in_valid;
    logic            in_ready;
    logic [N_PE-1:0] shifting_filter;
    logic [N_PE-1:0] shifting_line;
    logic [N_PE-1:0] mac_enable;
    logic            line_buffer_reset;
    logic            adder_enable;
    logic            nl_enable;
    logic            pool_enable;
    logic            final_filter_bank;
    logic [2:0]      nl_type;
    logic [W-1:0]    row_length;
    logic            busy;
    logic            done;
    logic            cfg_err;
    logic            out_valid;

    pe_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .cfg_row_length   (cfg_row_length),
        .cfg_num_rows     (cfg_num_rows),
        .cfg_ch_mask      (cfg_ch_mask),
        .cfg_final_bank   (cfg_final_bank),
        .cfg_pool_en      (cfg_pool_en),
        .cfg_nl_type      (cfg_nl_type),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .shifting_filter  (shifting_filter),
        .shifting_line    (shifting_line),
        .mac_enable       (mac_enable),
        .line_buffer_reset(line_buffer_reset),
        .adder_enable     (adder_enable),
        .nl_enable        (nl_enable),
        .pool_enable      (pool_enable),
        .final_filter_bank(final_filter_bank),
        .nl_type          (nl_type),
        .row_length       (row_length),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err),
        .out_valid        (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              rl;
        int              rows;
        logic [N_PE-1:0] mask;
        bit              pool;
        bit              fb;
        logic [2:0]      nlt;
        int              mode;
        int              exp_filt;
        int              exp_line;
        int              exp_mac;
        bit              exp_err;
    } job_t;

    job_t jobs[7];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int filt_cnt, line_cnt, mac_cnt, out_cnt, done_cnt, lbr_cnt, bad_cnt, done_cyc;
    logic            err_at_done;
    logic            fb_at_done;
    logic [2:0]      nlt_at_done;
    logic [W-1:0]    rl_at_done;
    logic [N_PE-1:0] cur_mask;
    bit              cur_pool;
    int              sb_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: strobe counts, protocol violations and the out_valid scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (shifting_filter != '0) begin
                filt_cnt++;
                if (!in_valid || shifting_filter != cur_mask) bad_cnt++;
            end
            if (shifting_line != '0) begin
                line_cnt++;
                if (!in_valid || shifting_line != cur_mask) bad_cnt++;
            end
            if (mac_enable != '0) begin
                mac_cnt++;
                if (mac_enable != cur_mask) bad_cnt++;
                sb_q.push_back(cyc + (cur_pool ? 8 : 7));
            end
            if (pool_enable && !cur_pool) bad_cnt++;
            if (out_valid) begin
                int exp_c;
                out_cnt++;
                exp_c = (sb_q.size() > 0) ? sb_q.pop_front() : -1;
                check("sb_out_cycle", cyc, exp_c);
            end
            if (done) begin
                done_cnt++;
                done_cyc    = cyc;
                err_at_done = cfg_err;
                rl_at_done  = row_length;
                fb_at_done  = final_filter_bank;
                nlt_at_done = nl_type;
            end
            if (line_buffer_reset) lbr_cnt++;
        end
    end

    task automatic clear_counts();
        filt_cnt = 0; line_cnt = 0; mac_cnt = 0; out_cnt = 0;
        done_cnt = 0; lbr_cnt = 0; bad_cnt = 0; done_cyc = 0;
        sb_q.delete();
    endtask

    // Called at #1 after a rising edge; start is held for exactly one edge.
    task automatic launch(input int rl, input int rows, input logic [N_PE-1:0] mask,
                          input bit pool, input bit fb, input logic [2:0] nlt, output int st_cyc);
        cur_mask       = mask;
        cur_pool       = pool;
        cfg_row_length = W'(rl);
        cfg_num_rows   = W'(rows);
        cfg_ch_mask    = mask;
        cfg_pool_en    = pool;
        cfg_final_bank = fb;
        cfg_nl_type    = nlt;
        start          = 1'b1;
        st_cyc         = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input job_t j, input int idx);
        int st_cyc;
        int t;
        clear_counts();
        launch(j.rl, j.rows, j.mask, j.pool, j.fb, j.nlt, st_cyc);
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            case (j.mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (t % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check($sformatf("job%0d_done_pulses", idx), done_cnt, 1);
        check($sformatf("job%0d_cfg_err", idx), err_at_done, j.exp_err);
        check($sformatf("job%0d_filt", idx), filt_cnt, j.exp_filt);
        check($sformatf("job%0d_line", idx), line_cnt, j.exp_line);
        check($sformatf("job%0d_mac", idx), mac_cnt, j.exp_mac);
        check($sformatf("job%0d_out", idx), out_cnt, j.exp_mac);
        check($sformatf("job%0d_violations", idx), bad_cnt, 0);
        check($sformatf("job%0d_lbr", idx), lbr_cnt, j.exp_err ? 0 : 1);
        check($sformatf("job%0d_row_length", idx), rl_at_done, j.rl);
        check($sformatf("job%0d_final_bank", idx), fb_at_done, j.fb);
        check($sformatf("job%0d_nl_type", idx), nlt_at_done, j.nlt);
        check($sformatf("job%0d_sb_empty", idx), sb_q.size(), 0);
        check($sformatf("job%0d_busy_after", idx), busy, 0);
        if (j.exp_err) check($sformatf("job%0d_err_done_lat", idx), done_cyc - st_cyc, 1);
    endtask

    initial begin
        int st_cyc;
        int t;
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        cfg_row_length = '0; cfg_num_rows = '0; cfg_ch_mask = '0;
        cfg_final_bank = 1'b0; cfg_pool_en = 1'b0; cfg_nl_type = '0;
        cur_mask = '0; cur_pool = 1'b0;
        clear_counts();

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_busy_done_err", {busy, done, cfg_err}, 0);
        check("rst_ready_out", {in_ready, out_valid, line_buffer_reset}, 0);
        check("rst_pipe", {adder_enable, nl_enable, pool_enable}, 0);
        check("rst_mac", mac_enable, 0);
        check("rst_cfg_copy", {final_filter_bank, nl_type, row_length}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        jobs[0] = '{5, 5, 32'hFFFF_FFFF, 1'b1, 1'b1, 3'd5, 0, 9, 25, 9, 1'b0};
        jobs[1] = '{5, 5, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'd2, 1, 9, 25, 9, 1'b0};
        jobs[2] = '{2, 5, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'd1, 0, 0, 0, 0, 1'b1};
        jobs[3] = '{5, 5, 32'hFFFF_FFFF, 1'b0, 1'b1, 3'd4, 0, 9, 25, 9, 1'b0};
        jobs[4] = '{4, 3, 32'h0000_00F0, 1'b1, 1'b0, 3'd7, 2, 9, 12, 2, 1'b0};
        jobs[5] = '{3, 3, 32'h0000_0001, 1'b0, 1'b1, 3'd0, 1, 9, 9, 1, 1'b0};
        jobs[6] = '{6, 2, 32'hFFFF_FFFF, 1'b1, 1'b1, 3'd3, 0, 0, 0, 0, 1'b1};

        for (int i = 0; i < 7; i++) run_job(jobs[i], i);

        // Abort in RUN right after the 3rd MAC pulse.
        clear_counts();
        launch(5, 5, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'd6, st_cyc);
        in_valid = 1'b1;
        t = 0;
        while (mac_cnt < 3 && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        check("abort_at_mac3", mac_cnt, 3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        sb_q.delete();
        lbr_cnt = 0; out_cnt = 0; done_cnt = 0;
        @(negedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_lbr_now", line_buffer_reset, 1);
        check("abort_ready", in_ready, 0);
        check("abort_mac", mac_enable, 0);
        repeat (20) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("abort_lbr_pulses", lbr_cnt, 1);
        check("abort_no_out", out_cnt, 0);
        check("abort_no_done", done_cnt, 0);

        // Start while RUN is ignored; job completes with its original config.
        clear_counts();
        launch(5, 5, 32'hFFFF_FFFF, 1'b0, 1'b1, 3'd3, st_cyc);
        in_valid = 1'b1;
        t = 0;
        while (mac_cnt < 1 && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        cfg_row_length = W'(7);
        cfg_nl_type    = 3'd1;
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("busy_start_mac", mac_cnt, 9);
        check("busy_start_out", out_cnt, 9);
        check("busy_start_done", done_cnt, 1);
        check("busy_start_row_length", rl_at_done, 5);
        check("busy_start_nl_type", nlt_at_done, 3);
        check("busy_start_idle_after", busy, 0);

        // Reset during PRIME.
        clear_counts();
        launch(5, 5, 32'hFFFF_FFFF, 1'b1, 1'b1, 3'd7, st_cyc);
        in_valid = 1'b1;
        t = 0;
        while (line_cnt < 3 && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        check("rst_prime_reached", line_cnt, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lbr_cnt = 0;
        @(negedge clk); #1;
        check("rstmid_status", {busy, done, cfg_err, in_ready, out_valid}, 0);
        check("rstmid_strobes", {shifting_filter, shifting_line, mac_enable}, 0);
        check("rstmid_lbr", line_buffer_reset, 0);
        check("rstmid_cfg_copy", {final_filter_bank, nl_type, row_length}, 0);
        line_cnt = 0;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rstmid_stays_idle", {busy, in_ready}, 0);
        check("rstmid_no_shift", line_cnt, 0);
        check("rstmid_no_lbr", lbr_cnt, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
